// File: rtl/spi_slave_nbit.sv
// -----------------------------------------------------------------------------
// spi_slave_nbit
//   Parametrised SPI slave. SCK, SPISTE and SPISIMO are oversampled on clk_100
//   through SYNC_STAGES-deep synchronisers. The slave provides a buffered TX
//   holding register with a load handshake, back-to-back word streaming while
//   SPISTE stays low, and mid-word abort detection.
//
// Parameters
//   DATA_W       bits per word (4..32)
//   CPOL         SCK idle level
//   CPHA         0: sample on leading edge, 1: sample on trailing edge
//   LSB_FIRST    0: MSB first on both lines, 1: LSB first
//   SYNC_STAGES  synchroniser depth (2..3)
//
// Ports
//   clk_100    system clock (SCK half-period >= SYNC_STAGES+3 cycles)
//   RSTn       asynchronous active-low reset
//   SPISTE     chip select, active low
//   SCK        SPI clock
//   SPISIMO    master-out data
//   SPISOMI    slave-out data, registered
//   tx_data    word to transmit
//   tx_load    one-cycle strobe, latches tx_data when tx_ready=1
//   tx_ready   holding register free
//   rx_data    last complete received word
//   rx_valid   one-cycle pulse, rx_data updated
//   busy       word in progress (bit counter != 0 or synced STE low)
//   frame_err  one-cycle pulse, STE rose mid-word
//
// Optional feature (macro SPI_SLAVE_OVERRUN_EN)
//   rx_rd       strobe, consumer has taken rx_data
//   rx_overrun  sticky, set when a new word lands before the previous one
//               was acknowledged; cleared by rx_rd (set wins on collision)
// -----------------------------------------------------------------------------
module spi_slave_nbit #(
    parameter int DATA_W      = 16,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b1,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_100,
    input  logic              RSTn,
    input  logic              SPISTE,
    input  logic              SCK,
    input  logic              SPISIMO,
    output logic              SPISOMI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    input  logic              rx_rd,
    output logic              rx_overrun
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ste_sync_q, ste_sync_d;
    logic [SYNC_STAGES-1:0] simo_sync_q, simo_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   ste_prev_q, ste_prev_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   somi_q, somi_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic sck_s, ste_s, simo_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic [DATA_W-1:0] tx_next;

    // Bit that goes on the wire first for a given word.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return LSB_FIRST ? w[0] : w[DATA_W-1];
    endfunction

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ste_s  = ste_sync_q[SYNC_STAGES-1];
    assign simo_s = simo_sync_q[SYNC_STAGES-1];

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge   = (sck_s != sck_prev_q) && (sck_s != CPOL);
    assign trail_edge  = (sck_s != sck_prev_q) && (sck_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign tx_next = LSB_FIRST ? {1'b0, tx_shift_q[DATA_W-1:1]}
                               : {tx_shift_q[DATA_W-2:0], 1'b0};

    always_comb begin
        // NOTE: every _d starts from its _q (or its pulse default) so that no
        // path through the case below leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        ste_sync_d  = {ste_sync_q[SYNC_STAGES-2:0], SPISTE};
        simo_sync_d = {simo_sync_q[SYNC_STAGES-2:0], SPISIMO};
        sck_prev_d  = sck_s;
        ste_prev_d  = ste_s;
        hold_d      = hold_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        somi_d      = somi_q;
        tx_ready_d  = tx_ready_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        // A load accepted in the LOAD cycle still wins: LOAD copies the old
        // holding value, the new one is kept for the following word.
        if (tx_load && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            tx_ready_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (!ste_s && ste_prev_q) state_d = ST_LOAD;
            end

            ST_LOAD: begin
                tx_shift_d = hold_q;
                if (!CPHA) somi_d = first_bit(hold_q);
                state_d = ST_ACTIVE;
            end

            ST_ACTIVE: begin
                if (bit_cnt_q == CNT_FULL) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = ste_s ? ST_IDLE : ST_LOAD;
                end else if (ste_s && !(sample_edge && bit_cnt_q == CNT_LAST)) begin
                    // STE rising together with the final sample edge lets the
                    // word complete; any other rise abandons the partial word.
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = LSB_FIRST ? {simo_s, rx_shift_q[DATA_W-1:1]}
                                               : {rx_shift_q[DATA_W-2:0], simo_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                    end
                    if (shift_edge) begin
                        // With CPHA=0 the first bit was driven in LOAD, so a
                        // shift edge before the first sample (the trailing edge
                        // left over from the previous word) is ignored.
                        if (bit_cnt_q == '0) begin
                            if (CPHA) somi_d = first_bit(tx_shift_q);
                        end else begin
                            tx_shift_d = tx_next;
                            somi_d     = first_bit(tx_next);
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= ST_IDLE;
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            ste_sync_q  <= '1;
            simo_sync_q <= '0;
            sck_prev_q  <= CPOL;
            ste_prev_q  <= 1'b1;
            hold_q      <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            somi_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            ste_sync_q  <= ste_sync_d;
            simo_sync_q <= simo_sync_d;
            sck_prev_q  <= sck_prev_d;
            ste_prev_q  <= ste_prev_d;
            hold_q      <= hold_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            somi_q      <= somi_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign SPISOMI   = somi_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (bit_cnt_q != '0) || !ste_s;

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_pending_q, rx_pending_d;
    logic rx_overrun_q, rx_overrun_d;

    // Pending tracks an unacknowledged word; a new word on top of it is an
    // overrun. The set term is evaluated last so it wins over rx_rd.
    always_comb begin
        rx_pending_d = rx_pending_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_rd) begin
            rx_pending_d = 1'b0;
            rx_overrun_d = 1'b0;
        end
        if (rx_valid_d) begin
            rx_pending_d = 1'b1;
            if (rx_pending_q) rx_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100 or negedge RSTn) begin
        if (!RSTn) begin
            rx_pending_q <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_pending_q <= rx_pending_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

    assign rx_overrun = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_nbit.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_nbit
//   Three slave instances in different modes are driven by a behavioural SPI
//   master. The expected received word is the word the master sent; the
//   expected transmitted word is the holding value tracked by a small model of
//   the load handshake. Latency, pulse counts and abort behaviour are checked
//   against fixed rules.
// -----------------------------------------------------------------------------
module tb_spi_slave_nbit;

    localparam int NDUT = 3;

    // Per-instance configuration (mirrors the instantiations below).
    int cfg_w    [NDUT] = '{16, 8, 12};
    bit cfg_cpol [NDUT] = '{1'b0, 1'b0, 1'b1};
    bit cfg_cpha [NDUT] = '{1'b1, 1'b0, 1'b0};
    bit cfg_lsb  [NDUT] = '{1'b0, 1'b1, 1'b0};
    int cfg_sync [NDUT] = '{2, 3, 2};

    logic clk_100 = 1'b0;
    logic RSTn;
    logic sck [NDUT], ste [NDUT], simo [NDUT], somi [NDUT];
    logic tx_load [NDUT], tx_ready [NDUT], rx_valid [NDUT], busy [NDUT], frame_err [NDUT];
    logic [15:0] tx0, rx0;
    logic [7:0]  tx1, rx1;
    logic [11:0] tx2, rx2;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_rd [NDUT], rx_overrun [NDUT];
`endif

    always #5 clk_100 = ~clk_100;

    spi_slave_nbit #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut0 (
        .clk_100(clk_100), .RSTn(RSTn), .SPISTE(ste[0]), .SCK(sck[0]), .SPISIMO(simo[0]),
        .SPISOMI(somi[0]), .tx_data(tx0), .tx_load(tx_load[0]), .tx_ready(tx_ready[0]),
        .rx_data(rx0), .rx_valid(rx_valid[0]), .busy(busy[0]), .frame_err(frame_err[0])
`ifdef SPI_SLAVE_OVERRUN_EN
        , .rx_rd(rx_rd[0]), .rx_overrun(rx_overrun[0])
`endif
    );

    spi_slave_nbit #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1), .SYNC_STAGES(3)) u_dut1 (
        .clk_100(clk_100), .RSTn(RSTn), .SPISTE(ste[1]), .SCK(sck[1]), .SPISIMO(simo[1]),
        .SPISOMI(somi[1]), .tx_data(tx1), .tx_load(tx_load[1]), .tx_ready(tx_ready[1]),
        .rx_data(rx1), .rx_valid(rx_valid[1]), .busy(busy[1]), .frame_err(frame_err[1])
`ifdef SPI_SLAVE_OVERRUN_EN
        , .rx_rd(rx_rd[1]), .rx_overrun(rx_overrun[1])
`endif
    );

    spi_slave_nbit #(.DATA_W(12), .CPOL(1'b1), .CPHA(1'b0), .LSB_FIRST(1'b0), .SYNC_STAGES(2)) u_dut2 (
        .clk_100(clk_100), .RSTn(RSTn), .SPISTE(ste[2]), .SCK(sck[2]), .SPISIMO(simo[2]),
        .SPISOMI(somi[2]), .tx_data(tx2), .tx_load(tx_load[2]), .tx_ready(tx_ready[2]),
        .rx_data(rx2), .rx_valid(rx_valid[2]), .busy(busy[2]), .frame_err(frame_err[2])
`ifdef SPI_SLAVE_OVERRUN_EN
        , .rx_rd(rx_rd[2]), .rx_overrun(rx_overrun[2])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int half    = 8;

    // Reference model of the TX holding register handshake.
    logic [31:0] hold_m  [NDUT];
    bit          ready_m [NDUT];

    // Observations collected by the monitor.
    int          rv_cnt  [NDUT] = '{default: 0};
    int          rv_cyc  [NDUT] = '{default: 0};
    int          fe_cnt  [NDUT] = '{default: 0};
    logic [31:0] rv_last [NDUT] = '{default: '0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_rx(input int s);
        case (s)
            0:       return 32'(rx0);
            1:       return 32'(rx1);
            default: return 32'(rx2);
        endcase
    endfunction

    function automatic logic [31:0] mask(input int s);
        return (32'h1 << cfg_w[s]) - 32'h1;
    endfunction

    always @(posedge clk_100) cyc <= cyc + 1;

    always @(negedge clk_100) begin
        for (int s = 0; s < NDUT; s++) begin
            if (rx_valid[s]) begin
                rv_cnt[s]  <= rv_cnt[s] + 1;
                rv_last[s] <= get_rx(s);
                rv_cyc[s]  <= cyc;
            end
            if (frame_err[s]) fe_cnt[s] <= fe_cnt[s] + 1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic model_reset();
        for (int s = 0; s < NDUT; s++) begin
            hold_m[s]  = '0;
            ready_m[s] = 1'b1;
        end
    endtask

    task automatic load_tx(input int s, input logic [31:0] v);
        @(negedge clk_100);
        case (s)
            0:       tx0 = v[15:0];
            1:       tx1 = v[7:0];
            default: tx2 = v[11:0];
        endcase
        tx_load[s] = 1'b1;
        @(negedge clk_100);
        tx_load[s] = 1'b0;
        if (ready_m[s]) begin
            hold_m[s]  = v & mask(s);
            ready_m[s] = 1'b0;
        end
        check($sformatf("tx_ready_after_load%0d", s), 32'(tx_ready[s]), 32'(ready_m[s]));
    endtask

    // Behavioural master: one word (or nbits of it) in the instance's mode.
    task automatic spi_word(input int s, input logic [31:0] mosi, input int nbits,
                            input bit rise_last, output logic [31:0] miso, output int last_cyc);
        miso     = '0;
        last_cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = cfg_lsb[s] ? i : cfg_w[s] - 1 - i;
            if (!cfg_cpha[s]) begin
                simo[s] = mosi[b];
                wait_clk(half);
                miso[b] = somi[s];
                sck[s]  = ~cfg_cpol[s];
                if (i == nbits - 1) last_cyc = cyc;
                wait_clk(half);
                sck[s]  = cfg_cpol[s];
            end else begin
                sck[s]  = ~cfg_cpol[s];
                simo[s] = mosi[b];
                wait_clk(half);
                miso[b] = somi[s];
                sck[s]  = cfg_cpol[s];
                if (i == nbits - 1) begin
                    last_cyc = cyc;
                    if (rise_last) ste[s] = 1'b1;
                end
                wait_clk(half);
            end
        end
    endtask

    // Full frame of nwords back-to-back words with all per-word checks.
    task automatic run_frame(input int s, input int nwords, input logic [31:0] words [3],
                             input bit rise_last, input bit mid_load, input logic [31:0] mid_val);
        int          fe0, rv0, lc;
        logic [31:0] miso, exp_miso;
        fe0    = fe_cnt[s];
        ste[s] = 1'b0;
        wait_clk(2 * half);
        for (int k = 0; k < nwords; k++) begin
            exp_miso   = hold_m[s];
            ready_m[s] = 1'b1;
            rv0        = rv_cnt[s];
            if (mid_load && k == 0) begin
                fork
                    spi_word(s, words[k], cfg_w[s], 1'b0, miso, lc);
                    begin
                        wait_clk(4 * half);
                        load_tx(s, mid_val);
                    end
                join
            end else begin
                spi_word(s, words[k], cfg_w[s], rise_last && (k == nwords - 1), miso, lc);
            end
            check($sformatf("rx_pulses%0d", s), 32'(rv_cnt[s] - rv0), 32'd1);
            check($sformatf("rx_data%0d", s), rv_last[s], words[k] & mask(s));
            check($sformatf("master_read%0d", s), miso, exp_miso);
            check($sformatf("latency%0d", s), 32'(rv_cyc[s] - lc), 32'(cfg_sync[s] + 2));
        end
        wait_clk(half);
        ste[s] = 1'b1;
        wait_clk(3 * half);
        check($sformatf("no_frame_err%0d", s), 32'(fe_cnt[s]), 32'(fe0));
        check($sformatf("tx_ready_end%0d", s), 32'(tx_ready[s]), 32'(ready_m[s]));
        check($sformatf("idle_busy%0d", s), 32'(busy[s]), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int s = 0; s < NDUT; s++) begin
            check($sformatf("%s_flags%0d", tag, s),
                  32'({somi[s], rx_valid[s], tx_ready[s], busy[s], frame_err[s]}), 32'b00100);
            check($sformatf("%s_rx%0d", tag, s), get_rx(s), 32'd0);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] words [3];
        logic [31:0] rx_before, miso_tmp;
        int          fe0, rv0, lc, s, nw;

        RSTn = 1'b0;
        tx0 = '0; tx1 = '0; tx2 = '0;
        for (int i = 0; i < NDUT; i++) begin
            sck[i] = cfg_cpol[i]; ste[i] = 1'b1; simo[i] = 1'b0; tx_load[i] = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
            rx_rd[i] = 1'b0;
`endif
        end
        model_reset();
        wait_clk(3);
        check_reset_state("reset");
        RSTn = 1'b1;
        wait_clk(3);

        // First frame after reset without a load transmits zero.
        words = '{32'h5A, 32'h0, 32'h0};
        run_frame(1, 1, words, 1'b0, 1'b0, '0);

        // Default mode 1, 16-bit MSB first.
        load_tx(0, 32'hA5C3);
        words = '{32'h1234, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);

        // Mode 0, 8-bit LSB first; first bit must be on SOMI before any edge.
        load_tx(1, 32'h81);
        words = '{32'h3C, 32'h0, 32'h0};
        run_frame(1, 1, words, 1'b0, 1'b0, '0);

        // Back-to-back words with BEEF loaded while word 1 is shifting.
        load_tx(0, 32'h1357);
        words = '{32'hCAFE, 32'h0F0F, 32'h0};
        run_frame(0, 2, words, 1'b0, 1'b1, 32'hBEEF);

        // Abort after 7 of 16 bits.
        rx_before = get_rx(0);
        fe0 = fe_cnt[0];
        rv0 = rv_cnt[0];
        ste[0] = 1'b0;
        wait_clk(2 * half);
        ready_m[0] = 1'b1;
        spi_word(0, 32'h7E81, 7, 1'b0, miso_tmp, lc);
        check("busy_mid_word", 32'(busy[0]), 32'd1);
        ste[0] = 1'b1;
        wait_clk(3 * half);
        check("abort_frame_err", 32'(fe_cnt[0] - fe0), 32'd1);
        check("abort_no_valid", 32'(rv_cnt[0] - rv0), 32'd0);
        check("abort_rx_kept", get_rx(0), rx_before);
        words = '{32'h2468, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);

        // Underrun: holding value retransmitted, tx_ready stays 1.
        load_tx(0, 32'h00FF);
        words = '{32'h1111, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);
        words = '{32'h2222, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);

        // STE rising together with the final sample edge completes the word.
        words = '{32'h9ABC, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b1, 1'b0, '0);

        // A second load while the holding register is full is ignored.
        load_tx(2, 32'hABC);
        load_tx(2, 32'h123);
        words = '{32'h5A5, 32'h0, 32'h0};
        run_frame(2, 1, words, 1'b0, 1'b0, '0);

        // Randomised traffic across all instances.
        for (int it = 0; it < 12; it++) begin
            s    = $urandom_range(0, NDUT - 1);
            half = $urandom_range(cfg_sync[s] + 3, 10);
            nw   = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) load_tx(s, $urandom());
            for (int k = 0; k < 3; k++) words[k] = $urandom();
            run_frame(s, nw, words, 1'b0, 1'b0, '0);
        end
        half = 8;

`ifdef SPI_SLAVE_OVERRUN_EN
        @(negedge clk_100); rx_rd[0] = 1'b1;
        @(negedge clk_100); rx_rd[0] = 1'b0;
        check("overrun_cleared", 32'(rx_overrun[0]), 32'd0);
        words = '{32'h0A0A, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);
        check("overrun_first_word", 32'(rx_overrun[0]), 32'd0);
        words = '{32'h0B0B, 32'h0, 32'h0};
        run_frame(0, 1, words, 1'b0, 1'b0, '0);
        check("overrun_set", 32'(rx_overrun[0]), 32'd1);
        @(negedge clk_100); rx_rd[0] = 1'b1;
        @(negedge clk_100); rx_rd[0] = 1'b0;
        check("overrun_rd_clear", 32'(rx_overrun[0]), 32'd0);
`endif

        // Reset asserted mid-word returns everything to reset values.
        load_tx(2, 32'hFED);
        ste[2] = 1'b0;
        wait_clk(2 * half);
        for (int i = 0; i < 3; i++) begin
            sck[2] = ~cfg_cpol[2];
            wait_clk(half);
            sck[2] = cfg_cpol[2];
            wait_clk(half);
        end
        check("busy_before_reset", 32'(busy[2]), 32'd1);
        RSTn = 1'b0;
        @(negedge clk_100);
        check_reset_state("midword_reset");
        ste[2] = 1'b1;
        wait_clk(3);
        RSTn = 1'b1;
        model_reset();
        wait_clk(3);
        words = '{32'h3C3, 32'h0, 32'h0};
        run_frame(2, 1, words, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
